// File: rtl/onehot_decoder_seq.sv
// -----------------------------------------------------------------------------
// onehot_decoder_seq
//
// Consumer-side companion of the 4-to-2 priority encoder. A binary code is
// accepted over a valid/ready handshake and regenerated as a one-hot strobe
// that is held for HOLD cycles, followed by GAP dead cycles before the next
// code is accepted. The encoder's "no input active" case arrives as in_zero
// and is replayed as an all-zero pattern with the same timing.
//
// Parameters
//   IN_W  code width; the output is OUT_W = 1 << IN_W lines wide
//   HOLD  cycles out/out_valid stay asserted per code (0 behaves as 1)
//   GAP   dead cycles after the hold phase before in_ready returns (0 allowed)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      code (or zero flag) present
//   in_ready   out  1      block can accept a code (combinational, IDLE only)
//   in_code    in   IN_W   binary index to decode
//   in_zero    in   1      1: emit the all-zero pattern, in_code ignored
//   out        out  OUT_W  registered one-hot (or all-zero) pattern
//   out_valid  out  1      out holds a decoded pattern
//   done       out  1      pulse on the final hold cycle
//   busy       out  1      block is in HOLD or GAP
// -----------------------------------------------------------------------------
module onehot_decoder_seq #(
  parameter int IN_W = 2,
  parameter int HOLD = 3,
  parameter int GAP  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_code,
  input  logic                 in_zero,
  output logic [(1<<IN_W)-1:0] out,
  output logic                 out_valid,
  output logic                 done,
  output logic                 busy
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int OUT_W    = 1 << IN_W;

  // A hold of zero cycles would make the code invisible, so it is treated as 1.
  localparam int HOLD_EFF = (HOLD < 1) ? 1 : HOLD;
  localparam int GAP_EFF  = (GAP  < 0) ? 0 : GAP;
  localparam bit HAS_GAP  = (GAP_EFF > 0);

  // One counter width serves both phases; the counters only ever load a
  // value below their phase length and count down, so they cannot wrap.
  localparam int CNT_MAX  = (HOLD_EFF > GAP_EFF) ? HOLD_EFF : GAP_EFF;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  // Counters hold "cycles remaining after this one", hence the minus one.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(HAS_GAP ? GAP_EFF - 1 : 0);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] gap_cnt;

  logic             accept;
  logic             hold_last;
  logic             gap_last;
  logic [OUT_W-1:0] decoded;

  // Every IN_W-bit code maps onto a line, so no range check is needed.
  assign decoded   = OUT_W'(1) << in_code;

  assign accept    = in_valid && in_ready;
  assign hold_last = (state_q == S_HOLD) && (hold_cnt == '0);
  assign gap_last  = (state_q == S_GAP)  && (gap_cnt  == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always written with <= so every register sees
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d is given its default before the case so that no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_last) begin
          state_d = HAS_GAP ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (combinational status lines)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    done     = hold_last;
  end

  // ---------------------------------------------------------------------------
  // Datapath: pattern register, valid flag and phase counters
  // ---------------------------------------------------------------------------
  // The pattern is registered on the accepting edge so the strobe appears one
  // cycle after the handshake and stays glitch-free for the whole hold phase.
  // Clearing out/out_valid on the last hold edge means out_valid is high for
  // exactly HOLD_EFF cycles; GAP then only delays the return of in_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            out       <= in_zero ? '0 : decoded;
            out_valid <= 1'b1;
            hold_cnt  <= HOLD_LOAD;
          end
        end
        S_HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else begin
            out       <= '0;
            out_valid <= 1'b0;
            gap_cnt   <= GAP_LOAD;
          end
        end
        S_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          out       <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// -----------------------------------------------------------------------------
// tb_onehot_decoder_seq
//
// Two instances share one reset: "a" uses the default HOLD=3/GAP=1 timing,
// "b" uses HOLD=1/GAP=0 (back-to-back codes). A driver process issues
// requests, predicts accepts from a timing model (a code accepted at edge A
// makes the block ready again HOLD+GAP edges later) and pushes the expected
// pattern with its accept edge into a per-instance queue. A monitor process
// checks out/out_valid/done against the queue front every cycle.
// -----------------------------------------------------------------------------
module tb_onehot_decoder_seq;

  localparam int HA = 3;
  localparam int GA = 1;
  localparam int HB = 1;
  localparam int GB = 0;

  typedef struct {
    logic [3:0] pat;
    int         acc;  // edge at which the code was accepted
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       req_v [2];
  logic [1:0] req_c [2];
  logic       req_z [2];

  logic       a_in_ready, a_out_valid, a_done, a_busy;
  logic [3:0] a_out;
  logic       b_in_ready, b_out_valid, b_done, b_busy;
  logic [3:0] b_out;

  int   n_tests;
  int   n_fail;
  int   edge_cnt;
  int   cur_k;
  int   last_acc [2];
  exp_t q0[$];
  exp_t q1[$];

  onehot_decoder_seq #(.IN_W(2), .HOLD(HA), .GAP(GA)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (req_v[0]),
    .in_ready  (a_in_ready),
    .in_code   (req_c[0]),
    .in_zero   (req_z[0]),
    .out       (a_out),
    .out_valid (a_out_valid),
    .done      (a_done),
    .busy      (a_busy)
  );

  onehot_decoder_seq #(.IN_W(2), .HOLD(HB), .GAP(GB)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (req_v[1]),
    .in_ready  (b_in_ready),
    .in_code   (req_c[1]),
    .in_zero   (req_z[1]),
    .out       (b_out),
    .out_valid (b_out_valid),
    .done      (b_done),
    .busy      (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int hold_of(input int i);
    return (i == 0) ? HA : HB;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? GA : GB;
  endfunction

  function automatic string nm(input int i);
    return (i == 0) ? "a" : "b";
  endfunction

  // After an accept at edge A the block needs HOLD+GAP further edges to idle.
  function automatic bit model_ready(input int i, input int k);
    return (k - last_acc[i]) >= (hold_of(i) + gap_of(i));
  endfunction

  function automatic logic [3:0] model_pat(input logic [1:0] c, input logic z);
    return z ? 4'b0000 : 4'(1 << c);
  endfunction

  function automatic int q_size(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_front(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic q_pop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic q_push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic logic get_ready(input int i);
    return (i == 0) ? a_in_ready : b_in_ready;
  endfunction

  function automatic logic get_busy(input int i);
    return (i == 0) ? a_busy : b_busy;
  endfunction

  task automatic new_req(input int i, input logic [1:0] c, input logic z);
    req_v[i] = 1'b1;
    req_c[i] = c;
    req_z[i] = z;
  endtask

  // Start of a cycle: sample handshake status against the model and retire
  // requests that were accepted on the edge just gone.
  task automatic cycle_begin();
    bit r;
    @(negedge clk);
    cur_k = edge_cnt;
    for (int i = 0; i < 2; i++) begin
      r = model_ready(i, cur_k);
      check($sformatf("%s_in_ready k=%0d", nm(i), cur_k), get_ready(i), r);
      check($sformatf("%s_busy k=%0d", nm(i), cur_k), get_busy(i), !r);
      if (last_acc[i] == cur_k) req_v[i] = 1'b0;
    end
  endtask

  // End of a cycle: predict accepts on the coming edge and queue the result.
  task automatic cycle_end();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (req_v[i] && rst_n && model_ready(i, cur_k)) begin
        e.pat = model_pat(req_c[i], req_z[i]);
        e.acc = cur_k + 1;
        q_push(i, e);
        last_acc[i] = cur_k + 1;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      cycle_begin();
      cycle_end();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a_out"},       a_out,       0);
    check({tag, "_a_out_valid"}, a_out_valid, 0);
    check({tag, "_a_in_ready"},  a_in_ready,  1);
    check({tag, "_a_busy"},      a_busy,      0);
    check({tag, "_a_done"},      a_done,      0);
    check({tag, "_b_out"},       b_out,       0);
    check({tag, "_b_out_valid"}, b_out_valid, 0);
    check({tag, "_b_in_ready"},  b_in_ready,  1);
    check({tag, "_b_done"},      b_done,      0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares the presented output against the queue front
  // ---------------------------------------------------------------------------
  task automatic mon(input int i, input logic [3:0] o, input logic ov, input logic dn);
    int   k;
    int   j;
    exp_t f;
    bit   exp_v;
    k     = edge_cnt;
    exp_v = 1'b0;
    if (q_size(i) > 0) begin
      f     = q_front(i);
      exp_v = (f.acc <= k);
    end
    check($sformatf("%s_out_valid k=%0d", nm(i), k), ov, exp_v);
    if (exp_v) begin
      j = k - f.acc;
      check($sformatf("%s_out k=%0d", nm(i), k), o, f.pat);
      check($sformatf("%s_done k=%0d", nm(i), k), dn, (j == hold_of(i) - 1));
      if (j >= hold_of(i) - 1) q_pop(i);
    end else begin
      check($sformatf("%s_idle_out k=%0d", nm(i), k), o, 0);
      check($sformatf("%s_idle_done k=%0d", nm(i), k), dn, 0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        mon(0, a_out, a_out_valid, a_done);
        mon(1, b_out, b_out_valid, b_done);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  initial begin
    int idx [2];
    bit all_sent;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_v[i]    = 1'b0;
      req_c[i]    = 2'b00;
      req_z[i]    = 1'b0;
      last_acc[i] = -1000;
      idx[i]      = 0;
    end

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Single code 2 on default timing.
    cycle_begin();
    new_req(0, 2'd2, 1'b0);
    new_req(1, 2'd2, 1'b0);
    cycle_end();
    idle_cycles(8);

    // Sweep codes 0..3 with in_valid held high.
    all_sent = 1'b0;
    for (int c = 0; c < 40 && !all_sent; c++) begin
      cycle_begin();
      for (int i = 0; i < 2; i++) begin
        if (!req_v[i] && idx[i] < 4) begin
          new_req(i, 2'(idx[i]), 1'b0);
          idx[i]++;
        end
      end
      all_sent = (idx[0] == 4) && (idx[1] == 4) && !req_v[0] && !req_v[1];
      cycle_end();
    end
    check("sweep_complete", all_sent, 1);
    idle_cycles(8);

    // Zero flag with a code that must be ignored.
    cycle_begin();
    new_req(0, 2'd3, 1'b1);
    new_req(1, 2'd3, 1'b1);
    cycle_end();
    idle_cycles(8);

    // Reset asserted during the second hold cycle of code 1.
    cycle_begin();
    new_req(0, 2'd1, 1'b0);
    new_req(1, 2'd1, 1'b0);
    cycle_end();
    cycle_begin();
    cycle_end();
    cycle_begin();
    rst_n = 1'b0;
    cycle_end();
    @(negedge clk);
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      req_v[i]    = 1'b0;
      last_acc[i] = -1000;
    end
    check_reset_state("midhold_reset");
    rst_n = 1'b1;
    idle_cycles(3);

    // in_valid held high with random codes (back-to-back on instance b).
    for (int c = 0; c < 30; c++) begin
      cycle_begin();
      for (int i = 0; i < 2; i++) begin
        if (!req_v[i]) new_req(i, 2'($urandom_range(0, 3)), 1'b0);
      end
      cycle_end();
    end

    // Random traffic including the zero flag.
    for (int c = 0; c < 400; c++) begin
      cycle_begin();
      for (int i = 0; i < 2; i++) begin
        if (!req_v[i] && $urandom_range(0, 2) != 0) begin
          new_req(i, 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end
      end
      cycle_end();
    end

    // Drain and confirm every expected output was seen.
    for (int c = 0; c < 12; c++) begin
      cycle_begin();
      for (int i = 0; i < 2; i++) req_v[i] = 1'b0;
      cycle_end();
    end
    check("a_queue_drained", q0.size(), 0);
    check("b_queue_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
